// File: rtl/usb_hid_pkg.sv
// usb_hid_pkg: shared types and report helpers for the HID key reporter
package usb_hid_pkg;
    localparam int HID_RPT_LEN = 8;

    typedef enum logic [1:0] {IDLE, PRESS, RELEASE} rpt_st_t;
    typedef enum logic [1:0] {TX_IDLE, SEND, WAIT_ACK} tx_st_t;

    typedef struct packed {
        logic [7:0] modifier;
        logic [7:0] keycode;
    } hid_key_t;

    // byte idx of the boot-keyboard report; a release report is all zeros
    function automatic logic [7:0] rpt_byte(hid_key_t k, logic rel, logic [2:0] idx);
        return rel ? 8'h00 : (idx == 3'd0) ? k.modifier : (idx == 3'd2) ? k.keycode : 8'h00;
    endfunction
endpackage

// File: rtl/usb_hid_req_fifo.sv
// usb_hid_req_fifo: request FIFO holding key events not yet reported
module usb_hid_req_fifo
    import usb_hid_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rstn,
    input  logic     push,
    input  logic     pop,
    input  hid_key_t din,
    output hid_key_t dout,
    output logic     full,
    output logic     empty
);
    localparam int AW = $clog2(DEPTH);

    hid_key_t    mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
    assign dout  = mem[rd_ptr[AW-1:0]];

    // storage is written on every accepted push; head is read combinationally
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    // pointers carry an extra wrap bit to tell full from empty
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/usb_hid_key_reporter.sv
// usb_hid_key_reporter: turns key requests into HID boot-keyboard press/release IN reports
module usb_hid_key_reporter
    import usb_hid_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] key_value,
    input  logic        key_request,
    output logic        key_overflow,
    output logic        ep_in_has_data,
    input  logic        ep_in_start,
    output logic [7:0]  ep_in_data,
    output logic        ep_in_valid,
    input  logic        ep_in_ready,
    output logic        ep_in_last,
    input  logic        ep_in_ack
);
    localparam logic [2:0] LAST_IDX = 3'(HID_RPT_LEN - 1);

    rpt_st_t    rpt_st;
    tx_st_t     tx_st;
    hid_key_t   rpt_key;
    hid_key_t   fifo_dout;
    logic [2:0] idx;
    logic       req_ok;
    logic       ack_done;
    logic       pop;
    logic       push;
    logic       fifo_full;
    logic       fifo_empty;
    logic       rel;

    assign req_ok         = key_request && (key_value != 16'h0000);
    assign ack_done       = (tx_st == WAIT_ACK) && ep_in_ack;
    assign pop            = !fifo_empty && ((rpt_st == IDLE) || ((rpt_st == RELEASE) && ack_done));
    assign push           = req_ok && (!fifo_full || pop);
    assign rel            = (rpt_st == RELEASE);
    assign ep_in_has_data = (rpt_st != IDLE);

    usb_hid_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .din   (hid_key_t'(key_value)),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // report FSM: a pop always starts a press; an ack moves press->release->idle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rpt_st       <= IDLE;
            rpt_key      <= '0;
            key_overflow <= 1'b0;
        end else begin
            key_overflow <= req_ok && fifo_full && !pop;
            if (pop) rpt_key <= fifo_dout;
            if (pop) rpt_st <= PRESS;
            else if (ack_done) rpt_st <= (rpt_st == PRESS) ? RELEASE : IDLE;
        end
    end

    // stream FSM: registered byte output, restart from byte0 on a retransmit start
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_st       <= TX_IDLE;
            idx         <= '0;
            ep_in_valid <= 1'b0;
            ep_in_last  <= 1'b0;
            ep_in_data  <= 8'h00;
        end else begin
            case (tx_st)
                TX_IDLE, WAIT_ACK: begin
                    if (ack_done) tx_st <= TX_IDLE;
                    else if (ep_in_start && ep_in_has_data) begin
                        tx_st       <= SEND;
                        idx         <= '0;
                        ep_in_valid <= 1'b1;
                        ep_in_last  <= 1'b0;
                        ep_in_data  <= rpt_byte(rpt_key, rel, 3'd0);
                    end
                end
                SEND: begin
                    if (ep_in_ready) begin
                        if (idx == LAST_IDX) begin
                            tx_st       <= WAIT_ACK;
                            ep_in_valid <= 1'b0;
                            ep_in_last  <= 1'b0;
                        end else begin
                            idx        <= idx + 3'd1;
                            ep_in_data <= rpt_byte(rpt_key, rel, idx + 3'd1);
                            ep_in_last <= (idx + 3'd1 == LAST_IDX);
                        end
                    end
                end
                default: tx_st <= TX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_hid_key_reporter.sv
// tb_usb_hid_key_reporter: directed stimulus checked against a queue-based report model
module tb_usb_hid_key_reporter;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] key_value = 16'h0000;
    logic        key_request = 1'b0;
    logic        key_overflow;
    logic        ep_in_has_data;
    logic        ep_in_start = 1'b0;
    logic [7:0]  ep_in_data;
    logic        ep_in_valid;
    logic        ep_in_ready = 1'b1;
    logic        ep_in_last;
    logic        ep_in_ack = 1'b0;

    int total = 0;
    int bad = 0;

    usb_hid_key_reporter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .key_value      (key_value),
        .key_request    (key_request),
        .key_overflow   (key_overflow),
        .ep_in_has_data (ep_in_has_data),
        .ep_in_start    (ep_in_start),
        .ep_in_data     (ep_in_data),
        .ep_in_valid    (ep_in_valid),
        .ep_in_ready    (ep_in_ready),
        .ep_in_last     (ep_in_last),
        .ep_in_ack      (ep_in_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // model: pending keys, the key being reported, reports left for it, stream position
    logic [15:0] kq[$];
    logic [15:0] m_cur = 16'h0000;
    int          m_rem = 0;
    int          m_pos = -1;
    bit          m_ovf = 1'b0;
    bit          m_ackd, m_popm, m_ok;

    function automatic logic [7:0] mbyte(logic [15:0] k, int r, int p);
        logic [7:0] rpt [8];
        foreach (rpt[i]) rpt[i] = 8'h00;
        if (r == 2) begin
            rpt[0] = k[15:8];
            rpt[2] = k[7:0];
        end
        return (p >= 0 && p < 8) ? rpt[p] : 8'h00;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            kq.delete();
            m_cur = 16'h0000;
            m_rem = 0;
            m_pos = -1;
            m_ovf = 1'b0;
        end else begin
            m_ackd = (m_pos == 8) && ep_in_ack;
            m_popm = (kq.size() > 0) && (m_rem == 0 || (m_rem == 1 && m_ackd));
            m_ok   = key_request && (key_value != 16'h0000);
            m_ovf  = m_ok && (kq.size() == DEPTH) && !m_popm;
            if (m_pos < 0) begin
                if (ep_in_start && m_rem > 0) m_pos = 0;
            end else if (m_pos < 8) begin
                if (ep_in_ready) m_pos++;
            end else if (ep_in_ack) m_pos = -1;
            else if (ep_in_start) m_pos = 0;
            if (m_ackd) m_rem--;
            if (m_popm) begin
                m_cur = kq.pop_front();
                m_rem = 2;
            end
            if (m_ok && !m_ovf) kq.push_back(key_value);
        end
    end

    // per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("has_data", 64'(ep_in_has_data), 64'(m_rem > 0));
        chk("valid", 64'(ep_in_valid), 64'(m_pos >= 0 && m_pos < 8));
        chk("last", 64'(ep_in_last), 64'(m_pos == 7));
        chk("data", 64'(ep_in_data), 64'(mbyte(m_cur, m_rem, m_pos)));
        chk("overflow", 64'(key_overflow), 64'(m_ovf));
    end

    // collect handshaked bytes into packets, count valid cycles and overflow pulses
    logic [7:0]  cap[$];
    logic [63:0] pkts[$];
    logic [63:0] pk;
    int          vcnt = 0;
    int          ovf_cnt = 0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) cap.delete();
        else begin
            if (ep_in_valid) vcnt++;
            if (key_overflow) ovf_cnt++;
            if (ep_in_valid && ep_in_ready) begin
                cap.push_back(ep_in_data);
                if (ep_in_last) begin
                    pk = '0;
                    foreach (cap[i]) pk = {pk[55:0], cap[i]};
                    pkts.push_back(pk);
                    cap.delete();
                end
            end
        end
    end

    task automatic step(input logic r, input logic [15:0] kv, input logic s, input logic rd, input logic a);
        key_request = r;
        key_value   = kv;
        ep_in_start = s;
        ep_in_ready = rd;
        ep_in_ack   = a;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic in_poll(input bit do_ack, input bit tog);
        int n0 = pkts.size();
        step(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 40 && pkts.size() == n0; i++)
            step(1'b0, 16'h0000, 1'b0, tog ? i[0] : 1'b1, 1'b0);
        chk("pkt_done", 64'(pkts.size()), 64'(n0 + 1));
        if (do_ack) step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int v0, o0, n0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_has", 64'(ep_in_has_data), 64'd0);
        chk("rst_valid", 64'(ep_in_valid), 64'd0);
        chk("rst_data", 64'(ep_in_data), 64'd0);
        chk("rst_last", 64'(ep_in_last), 64'd0);
        chk("rst_ovf", 64'(key_overflow), 64'd0);
        rstn = 1'b1;
        idle(2);

        // single key: press then release, has_data two cycles after request
        step(1'b1, 16'h0004, 1'b0, 1'b1, 1'b0);
        chk("lat_has0", 64'(ep_in_has_data), 64'd0);
        idle(1);
        chk("lat_has1", 64'(ep_in_has_data), 64'd1);
        v0 = vcnt;
        in_poll(1'b1, 1'b0);
        chk("t1_press", pkts[$], 64'h0000_0400_0000_0000);
        chk("t1_vcnt", 64'(vcnt - v0), 64'd8);
        in_poll(1'b1, 1'b0);
        chk("t1_rel", pkts[$], 64'h0);
        idle(2);
        chk("t1_has_end", 64'(ep_in_has_data), 64'd0);

        // burst: one key held, four queued, the sixth dropped
        o0 = ovf_cnt;
        for (int k = 4; k <= 9; k++) step(1'b1, 16'(k), 1'b0, 1'b1, 1'b0);
        idle(2);
        chk("burst_ovf", 64'(ovf_cnt - o0), 64'd1);
        for (int k = 4; k <= 8; k++) begin
            in_poll(1'b1, 1'b0);
            chk("burst_press", pkts[$], {16'h0000, 8'(k), 40'h0});
            in_poll(1'b1, 1'b0);
            chk("burst_rel", pkts[$], 64'h0);
        end
        idle(2);
        chk("burst_has_end", 64'(ep_in_has_data), 64'd0);

        // lost ack: same press resent, release only after ack
        step(1'b1, 16'h0204, 1'b0, 1'b1, 1'b0);
        idle(2);
        in_poll(1'b0, 1'b0);
        chk("rtx_first", pkts[$], 64'h0200_0400_0000_0000);
        idle(2);
        chk("rtx_has", 64'(ep_in_has_data), 64'd1);
        in_poll(1'b1, 1'b0);
        chk("rtx_again", pkts[$], 64'h0200_0400_0000_0000);
        in_poll(1'b1, 1'b0);
        chk("rtx_rel", pkts[$], 64'h0);

        // stalled stream: ready toggling every cycle
        step(1'b1, 16'h0105, 1'b0, 1'b1, 1'b0);
        idle(2);
        v0 = vcnt;
        in_poll(1'b1, 1'b1);
        chk("stall_press", pkts[$], 64'h0100_0500_0000_0000);
        chk("stall_vcnt", 64'(vcnt - v0), 64'd16);
        in_poll(1'b1, 1'b0);
        chk("stall_rel", pkts[$], 64'h0);
        idle(2);

        // ignored inputs: start with nothing pending, stray ack, zero key
        n0 = pkts.size();
        step(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        step(1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
        idle(3);
        chk("ign_has", 64'(ep_in_has_data), 64'd0);
        chk("ign_valid", 64'(ep_in_valid), 64'd0);
        chk("ign_pkts", 64'(pkts.size()), 64'(n0));

        // reset at byte 3 of a press, with a second key queued
        step(1'b1, 16'h0006, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h0007, 1'b0, 1'b1, 1'b0);
        idle(1);
        step(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        idle(3);
        chk("mid_valid", 64'(ep_in_valid), 64'd1);
        rstn = 1'b0;
        #1;
        chk("mr_has", 64'(ep_in_has_data), 64'd0);
        chk("mr_valid", 64'(ep_in_valid), 64'd0);
        chk("mr_data", 64'(ep_in_data), 64'd0);
        chk("mr_last", 64'(ep_in_last), 64'd0);
        chk("mr_ovf", 64'(key_overflow), 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(4);
        chk("mr_has_after", 64'(ep_in_has_data), 64'd0);
        chk("mr_pkts", 64'(pkts.size()), 64'(n0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
